// File: rtl/controle_pilha.sv
// Stack-machine controller: accepts PUSH/POP/ALU commands, sequences the strobes
// of an external stack with a registered read port, and returns one response per command.
module controle_pilha #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             pilha_push,
  output logic             pilha_pop,
  output logic [WIDTH-1:0] pilha_din,
  input  logic [WIDTH-1:0] pilha_dout,
  input  logic [15:0]      pilha_tos,
  output logic [2:0]       dbg_state
);

  // Handshakes: a transfer happens on the rising edge where valid && ready;
  // valid never waits on ready, and the payload is held stable while valid is high.

  localparam logic [2:0] OP_PUSH = 3'b000;
  localparam logic [2:0] OP_POP  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_BAD  = 3'b111;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_POP_A  = 3'd1,
    S_WAIT_A = 3'd2,
    S_POP_B  = 3'd3,
    S_WAIT_B = 3'd4,
    S_PUSH_R = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             armed_q;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;

  logic             accept;
  logic             acc_err;
  logic [WIDTH-1:0] alu_r;

  // armed_q keeps cmd_ready low until the first edge after reset release.
  assign accept = (state_q == S_IDLE) && armed_q && cmd_valid;

  always_comb begin
    acc_err = 1'b0;
    case (cmd_op)
      OP_PUSH: acc_err = (pilha_tos >= DEPTH_W);
      OP_POP:  acc_err = (pilha_tos == 16'd0);
      OP_BAD:  acc_err = 1'b1;
      default: acc_err = (pilha_tos < 16'd2);
    endcase
  end

  // In WAIT_B pilha_dout holds a (the deeper operand); b_q holds the former top.
  always_comb begin
    alu_r = '0;
    case (op_q)
      OP_ADD:  alu_r = pilha_dout + b_q;
      OP_SUB:  alu_r = pilha_dout - b_q;
      OP_AND:  alu_r = pilha_dout & b_q;
      OP_OR:   alu_r = pilha_dout | b_q;
      OP_XOR:  alu_r = pilha_dout ^ b_q;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (acc_err)               state_d = S_RESP;
          else if (cmd_op == OP_PUSH) state_d = S_PUSH_R;
          else                        state_d = S_POP_A;
        end
      end
      S_POP_A:  state_d = S_WAIT_A;
      S_WAIT_A: state_d = (op_q == OP_POP) ? S_RESP : S_POP_B;
      S_POP_B:  state_d = S_WAIT_B;
      S_WAIT_B: state_d = S_PUSH_R;
      S_PUSH_R: state_d = S_RESP;
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready  = (state_q == S_IDLE) && armed_q;
    resp_valid = (state_q == S_RESP);
    resp_data  = (state_q == S_RESP) ? res_q : '0;
    resp_err   = (state_q == S_RESP) && err_q;
    pilha_pop  = (state_q == S_POP_A) || (state_q == S_POP_B);
    pilha_push = (state_q == S_PUSH_R);
    pilha_din  = (state_q == S_PUSH_R) ? res_q : '0;
    dbg_state  = state_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q  <= OP_PUSH;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      op_q  <= op_d;
      b_q   <= b_d;
      res_q <= res_d;
      err_q <= err_d;
    end
  end

  // res_q carries the immediate for PUSH, the popped word for POP and r for ALU ops.
  always_comb begin
    op_d  = op_q;
    b_d   = b_q;
    res_d = res_q;
    err_d = err_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = cmd_op;
          err_d = acc_err;
          b_d   = '0;
          res_d = acc_err ? '0 : cmd_imm;
        end
      end
      S_WAIT_A: begin
        b_d   = pilha_dout;
        res_d = pilha_dout;
      end
      S_WAIT_B: res_d = alu_r;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_pilha.sv
// Bench for controle_pilha: behavioural stack model on the memory side, queue-based
// reference for expected responses, directed corner cases followed by random commands.
module tb_controle_pilha;

  localparam int W = 16;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_imm = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic         pilha_push;
  logic         pilha_pop;
  logic [W-1:0] pilha_din;
  logic [W-1:0] pilha_dout = '0;
  logic [15:0]  pilha_tos;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  controle_pilha #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_imm(cmd_imm),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .pilha_push(pilha_push), .pilha_pop(pilha_pop), .pilha_din(pilha_din),
    .pilha_dout(pilha_dout), .pilha_tos(pilha_tos), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // external stack: registered read port, unaffected by the controller reset
  logic [W-1:0] mem [D];
  int cnt = 0;
  assign pilha_tos = 16'(cnt);

  always @(posedge clk) begin
    if (pilha_pop && cnt > 0) begin
      pilha_dout <= mem[cnt-1];
      cnt <= cnt - 1;
    end else if (pilha_push && cnt < D) begin
      mem[cnt] <= pilha_din;
      cnt <= cnt + 1;
    end
  end

  int n_push = 0;
  int n_pop  = 0;
  int n_both = 0;
  always @(posedge clk) begin
    if (pilha_push) n_push++;
    if (pilha_pop) n_pop++;
    if (pilha_push && pilha_pop) n_both++;
  end

  // reference model and scoreboard
  logic [W-1:0] ref_q[$];
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (op)
      3'd2: return W'(int'(a) + int'(b));
      3'd3: return W'(int'(a) - int'(b));
      3'd4: return a & b;
      3'd5: return a | b;
      default: return a ^ b;
    endcase
  endfunction

  task automatic model(input logic [2:0] op, input logic [W-1:0] imm,
                       output logic exp_err, output int exp_lat,
                       output int exp_pops, output int exp_pushes);
    logic [W-1:0] a, b, r;
    exp_err = 1'b1; exp_lat = 1; exp_pops = 0; exp_pushes = 0; r = '0;
    if (op == 3'd0) begin
      if (ref_q.size() < D) begin
        ref_q.push_back(imm); r = imm;
        exp_err = 1'b0; exp_lat = 2; exp_pushes = 1;
      end
    end else if (op == 3'd1) begin
      if (ref_q.size() > 0) begin
        r = ref_q.pop_back();
        exp_err = 1'b0; exp_lat = 3; exp_pops = 1;
      end
    end else if (op != 3'd7) begin
      if (ref_q.size() >= 2) begin
        b = ref_q.pop_back();
        a = ref_q.pop_back();
        r = ref_alu(op, a, b);
        ref_q.push_back(r);
        exp_err = 1'b0; exp_lat = 6; exp_pops = 2; exp_pushes = 1;
      end
    end
    exp_q.push_back(r);
  endtask

  task automatic wait_ready();
    int waitc = 0;
    @(negedge clk);
    while (!cmd_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk("ready_wait", 32'(cmd_ready), 32'd1);
  endtask

  // driver: one command, optional response back-pressure, junk cmd_valid while busy
  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] imm, input int hold);
    logic exp_err;
    int exp_lat, exp_pops, exp_pushes, lat, p0, q0;
    logic [W-1:0] exp_d, held;
    model(op, imm, exp_err, exp_lat, exp_pops, exp_pushes);
    wait_ready();
    p0 = n_push; q0 = n_pop;
    cmd_valid = 1'b1; cmd_op = op; cmd_imm = imm;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op = 3'($urandom);
    cmd_imm = W'($urandom);
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    exp_d = exp_q.pop_front();
    if (!resp_valid) begin
      cmd_valid = 1'b0;
      return;
    end
    chk("resp_data", 32'(resp_data), 32'(exp_d));
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", 32'(resp_data), 32'(held));
      chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("ready_after_resp", 32'(cmd_ready), 32'd1);
    chk("resp_valid_drop", 32'(resp_valid), 32'd0);
    chk("pop_strobes", 32'(n_pop - q0), 32'(exp_pops));
    chk("push_strobes", 32'(n_push - p0), 32'(exp_pushes));
    chk("tos", 32'(pilha_tos), 32'(ref_q.size()));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_push"}, 32'(pilha_push), 32'd0);
    chk({tag, "_pop"}, 32'(pilha_pop), 32'd0);
    chk({tag, "_din"}, 32'(pilha_din), 32'd0);
  endtask

  initial begin
    int p0, q0;
    logic [2:0] op;
    #1;
    chk_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("ready_first_edge", 32'(cmd_ready), 32'd1);

    // PUSH 5, PUSH 3, SUB -> 2
    run_cmd(3'd0, 16'd5, 0);
    run_cmd(3'd0, 16'd3, 0);
    run_cmd(3'd3, 16'd0, 0);
    // drain, then POP on empty stack
    run_cmd(3'd1, 16'd0, 0);
    run_cmd(3'd1, 16'd0, 0);
    // fill to DEPTH, overflow attempt, drain
    for (int i = 0; i < D; i++) run_cmd(3'd0, W'($urandom), 0);
    run_cmd(3'd0, 16'h1234, 0);
    for (int i = 0; i < D; i++) run_cmd(3'd1, 16'd0, 0);
    // wraparound add and xor
    run_cmd(3'd0, 16'hFFFF, 0);
    run_cmd(3'd0, 16'h0001, 0);
    run_cmd(3'd2, 16'd0, 0);
    run_cmd(3'd1, 16'd0, 0);
    run_cmd(3'd0, 16'h00F0, 0);
    run_cmd(3'd0, 16'h0FF0, 1);
    run_cmd(3'd6, 16'd0, 2);
    run_cmd(3'd1, 16'd0, 0);
    // invalid opcode and binary op with too few entries
    run_cmd(3'd7, 16'hBEEF, 0);
    run_cmd(3'd4, 16'd0, 0);
    // back-pressure on a POP response
    run_cmd(3'd0, 16'hABCD, 0);
    run_cmd(3'd1, 16'd0, 5);

    // reset during WAIT_B of an ADD
    run_cmd(3'd0, 16'h1111, 0);
    run_cmd(3'd0, 16'h2222, 0);
    wait_ready();
    p0 = n_push; q0 = n_pop;
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_imm = '0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_outputs_zero("midop_reset");
    void'(ref_q.pop_back());
    void'(ref_q.pop_back());
    repeat (2) @(negedge clk);
    chk("midop_pops", 32'(n_pop - q0), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midop_ready", 32'(cmd_ready), 32'd1);
    chk("midop_no_push", 32'(n_push - p0), 32'd0);
    chk("midop_tos", 32'(pilha_tos), 32'(ref_q.size()));

    // random traffic
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = 3'd0;
        4, 5:       op = 3'd1;
        9:          op = 3'd7;
        default:    op = 3'($urandom_range(2, 6));
      endcase
      run_cmd(op, W'($urandom), int'($urandom_range(0, 2)));
    end

    chk("push_pop_overlap", 32'(n_both), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/controle_pilha.md
CONTROLE_PILHA -- requirements
Module: controle_pilha

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of operands, results and stack words.
REQ-002 SHALL have parameter DEPTH, default 16: number of stack entries.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1: command present.
REQ-006 SHALL have port cmd_ready  output  1: controller accepts a command this cycle.
REQ-007 SHALL have port cmd_op  input  3: opcode, encoded 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 invalid.
REQ-008 SHALL have port cmd_imm  input  WIDTH: immediate value, used only by PUSH.
REQ-009 SHALL have port resp_valid  output  1: response present.
REQ-010 SHALL have port resp_ready  input  1: consumer accepts the response.
REQ-011 SHALL have port resp_data  output  WIDTH: result value.
REQ-012 SHALL have port resp_err  output  1: command rejected.
REQ-013 SHALL have port pilha_push  output  1: stack write strobe.
REQ-014 SHALL have port pilha_pop  output  1: stack read strobe.
REQ-015 SHALL have port pilha_din  output  WIDTH: stack write data.
REQ-016 SHALL have port pilha_dout  input  WIDTH: stack read data, registered, valid on the cycle after the pop strobe.
REQ-017 SHALL have port pilha_tos  input  16: stack entry count, 0..DEPTH.

Function
REQ-018 SHALL implement the states IDLE, POP_A, WAIT_A, POP_B, WAIT_B, PUSH_R and RESP.
REQ-019 SHALL drive cmd_ready=1 only in IDLE, and a command SHALL be accepted on cmd_valid&&cmd_ready, latching cmd_op and cmd_imm.
REQ-020 SHALL check on accept, with no stack strobe issued on error:
- PUSH with tos==DEPTH, POP with tos==0, binary op with tos<2, or op 111: go to RESP with resp_err=1 and resp_data=0.
REQ-021 SHALL, for a valid PUSH, go IDLE->PUSH_R->RESP, with pilha_din=cmd_imm and resp_data=cmd_imm.
REQ-022 SHALL, for a valid POP, go IDLE->POP_A->WAIT_A->RESP, with resp_data=pilha_dout captured in WAIT_A.
REQ-023 SHALL, for a valid binary op, go IDLE->POP_A->WAIT_A->POP_B->WAIT_B->PUSH_R->RESP:
- WAIT_A captures b (the top).
- WAIT_B computes r = a op b, where a is pilha_dout; SUB is a-b.
- PUSH_R pushes r.
- resp_data = r.
REQ-024 SHALL perform ADD/SUB modulo 2^WIDTH with no carry or overflow flag; AND/OR/XOR SHALL be bitwise.
REQ-025 SHALL assert pilha_pop for exactly one cycle in POP_A and POP_B only, and pilha_push for exactly one cycle in PUSH_R only, never both at once.
REQ-026 SHALL set pilha_din=0 outside PUSH_R.
REQ-027 SHALL hold resp_valid=1 in RESP with resp_data and resp_err stable until resp_ready; the transition to IDLE SHALL occur on resp_valid&&resp_ready.
REQ-028 SHALL have a latency from accept edge to resp_valid of: error 1 cycle, PUSH 2, POP 3, binary 6.
REQ-029 SHALL ignore cmd_valid outside IDLE; a held cmd_valid SHALL be accepted only after return to IDLE.
REQ-030 SHALL allow back-to-back commands: cmd_ready rises on the cycle after the response handshake.

Reset
REQ-031 SHALL, while rst==0, asynchronously force state=IDLE, cmd_ready=0, resp_valid=0, resp_data=0, resp_err=0, pilha_push=0, pilha_pop=0, pilha_din=0, and operand registers=0.
REQ-032 SHALL, on reset asserted mid-operation, abandon the command with no response and no further strobes; stack contents are not restored.
REQ-033 SHALL raise cmd_ready on the first clk edge after rst rises.

Verification
REQ-034 Empty stack, PUSH 5, PUSH 3, SUB -> responses 5, 3, 2 (err=0); tos ends 1; SUB response 6 cycles after accept.
REQ-035 tos=0, POP -> resp_err=1, resp_data=0 one cycle after accept; pilha_pop never asserted.
REQ-036 Push 16 values then PUSH -> 17th response err=1; tos stays 16; no push strobe.
REQ-037 Stack [0xFFFF, 0x0001], ADD -> resp_data=0x0000, err=0; then XOR with [0x00F0, 0x0FF0] -> 0x0F00.
REQ-038 Hold resp_ready=0 for 5 cycles on a POP response -> resp_valid and resp_data stable, cmd_ready=0, no strobes; IDLE on the cycle after resp_ready=1.
REQ-039 rst low during WAIT_B of an ADD -> all outputs 0 immediately; no push strobe afterwards; cmd_ready=1 one edge after rst rises.
